// File: rtl/fu_alu_cdb.sv
`default_nettype none
// ============================================================================
// Module      : fu_alu_cdb
// Description : 8-bit ALU functional unit. Takes issue pulses from the RS
//               chain, runs a LATENCY-stage execute pipe into a result FIFO
//               and broadcasts one result per cycle on the daisy-chained CDB.
// Revision    : 1.0 - initial release
// ============================================================================
module fu_alu_cdb #(
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            futransmit,
   input  logic [7:0]      operandin,
   input  logic [7:0]      wbsin,
   input  logic [1:0][7:0] depvalsin,
   input  logic [7:0]      flagin,
   input  logic [7:0]      robidin,
   output logic            fubusyout,
   input  logic            cdbclaimedin,
   output logic            cdbclaimedout,
   output logic            cdbvalid,
   output logic [3:0]      cdbtag,
   output logic [7:0]      cdbval,
   output logic [7:0]      cdbwbs,
   output logic [7:0]      cdbrobid,
   output logic [7:0]      cdbflag
);

   localparam int              c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              c_EW   = 26;
   localparam int              c_OW   = 16;
   localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

   // Entry layout: {wbs[25:18], robid[17:10], val[9:2], carry[1], zero[0]}
   logic [8:0]      w_sum;
   logic [8:0]      w_dif;
   logic [7:0]      w_res;
   logic            w_carry;
   logic [c_EW-1:0] w_entry;
   logic            w_unused;

   always_comb begin
      w_sum   = {1'b0, depvalsin[0]} + {1'b0, depvalsin[1]} + {8'b0, flagin[0]};
      w_dif   = {1'b0, depvalsin[0]} - {1'b0, depvalsin[1]} - {8'b0, flagin[0]};
      w_res   = 8'd0;
      w_carry = 1'b0;
      case (operandin)
         8'd0: begin w_res = w_sum[7:0]; w_carry = w_sum[8]; end
         8'd1: begin w_res = w_dif[7:0]; w_carry = w_dif[8]; end
         8'd2: w_res = depvalsin[0] & depvalsin[1];
         8'd3: w_res = depvalsin[0] | depvalsin[1];
         8'd4: w_res = depvalsin[0] ^ depvalsin[1];
         8'd5: w_res = depvalsin[0] << depvalsin[1][2:0];
         8'd6: w_res = depvalsin[0] >> depvalsin[1][2:0];
         8'd7: w_res = depvalsin[0];
         default: ;
      endcase
   end

   assign w_entry  = {wbsin, robidin, w_res, w_carry, (w_res == 8'd0)};
   assign w_unused = ^flagin[7:1];

   // Busy as seen by the RS at the last edge; an issue against it is dropped.
   logic r_busy_q;
   logic w_accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_busy_q <= 1'b0;
      else     r_busy_q <= fubusyout;
   end

   assign w_accept = futransmit & ~r_busy_q;

   logic            w_push;
   logic [c_EW-1:0] w_push_d;
   logic [c_OW-1:0] w_pipe_cnt;

   generate
      if (LATENCY > 1) begin : g_pipe
         logic [LATENCY-2:0] r_v;
         logic [c_EW-1:0]    r_d [LATENCY-1];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_v <= '0;
            end else begin
               r_v[0] <= w_accept;
               for (int i = 1; i < LATENCY - 1; i++) r_v[i] <= r_v[i-1];
            end
         end

         always_ff @(posedge clk) begin
            r_d[0] <= w_entry;
            for (int i = 1; i < LATENCY - 1; i++) r_d[i] <= r_d[i-1];
         end

         always_comb begin
            w_pipe_cnt = '0;
            for (int i = 0; i < LATENCY - 1; i++) w_pipe_cnt = w_pipe_cnt + c_OW'(r_v[i]);
         end

         assign w_push   = r_v[LATENCY-2];
         assign w_push_d = r_d[LATENCY-2];
      end else begin : g_direct
         assign w_push     = w_accept;
         assign w_push_d   = w_entry;
         assign w_pipe_cnt = '0;
      end
   endgenerate

   logic [c_EW-1:0] r_mem [DEPTH];
   logic [c_AW-1:0] r_wp;
   logic [c_AW-1:0] r_rp;
   logic [c_AW:0]   r_cnt;
   logic            w_pop;
   logic            w_wr;
   logic [c_EW-1:0] w_head;
   logic [c_OW-1:0] w_occ;

   assign w_pop = (r_cnt != '0) && !cdbclaimedin;
   assign w_wr  = w_push && ((r_cnt != c_FULL) || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr)  r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp] <= w_push_d;
   end

   // Counting the current issue covers the one-cycle lag before the RS sees busy.
   assign w_occ     = c_OW'(r_cnt) + w_pipe_cnt + c_OW'(futransmit);
   assign fubusyout = (w_occ >= c_OW'(DEPTH));

   assign w_head        = r_mem[r_rp];
   assign cdbvalid      = w_pop;
   assign cdbclaimedout = cdbclaimedin | w_pop;
   assign cdbtag        = w_pop ? w_head[13:10] : 4'd0;
   assign cdbval        = w_pop ? w_head[9:2]   : 8'd0;
   assign cdbwbs        = w_pop ? w_head[25:18] : 8'd0;
   assign cdbrobid      = w_pop ? w_head[17:10] : 8'd0;
   assign cdbflag       = w_pop ? {6'b0, w_head[1:0]} : 8'd0;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst) assert (!(futransmit && r_busy_q)) else $error("fu_alu_cdb: issue while busy");
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fu_alu_cdb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fu_alu_cdb
// Description : Self-checking bench for fu_alu_cdb against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_alu_cdb;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            futransmit, cdbclaimedin;
   logic [7:0]      operandin, wbsin, flagin, robidin;
   logic [1:0][7:0] depvalsin;
   logic            fubusyout, cdbclaimedout, cdbvalid;
   logic [3:0]      cdbtag;
   logic [7:0]      cdbval, cdbwbs, cdbrobid, cdbflag;

   fu_alu_cdb #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .futransmit(futransmit), .operandin(operandin),
      .wbsin(wbsin), .depvalsin(depvalsin), .flagin(flagin), .robidin(robidin),
      .fubusyout(fubusyout), .cdbclaimedin(cdbclaimedin), .cdbclaimedout(cdbclaimedout),
      .cdbvalid(cdbvalid), .cdbtag(cdbtag), .cdbval(cdbval), .cdbwbs(cdbwbs),
      .cdbrobid(cdbrobid), .cdbflag(cdbflag)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [38:0] obs;
   assign obs = {fubusyout, cdbclaimedout, cdbvalid, cdbtag, cdbval, cdbflag, cdbwbs, cdbrobid};

   // Reference model: in-flight results with their ready cycle, then a result queue.
   typedef struct { int ready; logic [35:0] ent; } pend_t;
   pend_t       pend_q[$];
   logic [35:0] fifo_q[$];
   bit          m_busy_prev;
   int          cyc;
   logic [38:0] exp_out;

   function automatic logic [35:0] alu_model(input logic [7:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic ci,
                                             input logic [7:0] wbs, input logic [7:0] rob);
      int r;
      int ia = a;
      int ib = b;
      int ic = ci;
      bit c = 0;
      case (op)
         8'd0: begin r = ia + ib + ic; c = (r > 255); end
         8'd1: begin r = ia - ib - ic; c = (r < 0); end
         8'd2: r = ia & ib;
         8'd3: r = ia | ib;
         8'd4: r = ia ^ ib;
         8'd5: r = ia << (ib % 8);
         8'd6: r = ia >> (ib % 8);
         8'd7: r = ia;
         default: r = 0;
      endcase
      r = r & 255;
      return {rob[3:0], 8'(r), {6'b0, c, (r == 0)}, wbs, rob};
   endfunction

   task automatic model_reset();
      pend_q.delete();
      fifo_q.delete();
      m_busy_prev = 0;
   endtask

   task automatic model_cycle(input bit tr, input bit cl, input logic [35:0] e);
      bit          bsy, vld;
      logic [35:0] ent;
      while (pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
         fifo_q.push_back(pend_q[0].ent);
         void'(pend_q.pop_front());
      end
      bsy = (fifo_q.size() + pend_q.size() + int'(tr)) >= DEPTH;
      vld = (fifo_q.size() > 0) && !cl;
      ent = vld ? fifo_q.pop_front() : 36'd0;
      exp_out = {bsy, cl | vld, vld, ent};
      if (tr && !m_busy_prev) pend_q.push_back('{cyc + LATENCY, e});
      m_busy_prev = bsy;
      cyc++;
   endtask

   task automatic cycle_in(input bit tr, input bit cl, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] fl, input logic [7:0] wbs,
                           input logic [7:0] rob);
      @(posedge clk); #1;
      futransmit   = tr;  cdbclaimedin = cl; operandin = op;
      depvalsin[0] = a;   depvalsin[1] = b;  flagin    = fl;
      wbsin        = wbs; robidin      = rob;
      model_cycle(tr, cl, alu_model(op, a, b, fl[0], wbs, rob));
      @(negedge clk);
   endtask

   task automatic rand_cycle(input bit tr, input bit cl);
      logic [7:0] op;
      op = ($urandom % 5 == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      cycle_in(tr, cl, op, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic test_reset();
      #2;
      if (obs !== 39'd0) begin errors++; $display("FAIL reset_idle got=%h exp=%h", obs, 39'd0); end
      checks++;
      cdbclaimedin = 1'b1; #1;
      if (obs !== {2'b01, 37'd0}) begin errors++; $display("FAIL reset_chain got=%h exp=%h", obs, {2'b01, 37'd0}); end
      checks++;
      cdbclaimedin = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_ops();
      cycle_in(1, 0, 8'd0, 8'hF0, 8'h20, 8'h00, 8'h33, 8'd5);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) cycle_in(0, 0, 0, 0, 0, 0, 0, 0);
         if (obs !== exp_out) begin errors++; $display("FAIL add_vec k=%0d got=%h exp=%h", k, obs, exp_out); end
         checks++;
         if (k == 1) cycle_in(0, 0, 0, 0, 0, 0, 0, 0);
         if (k == 1) begin
            if ({cdbvalid, cdbtag, cdbval, cdbflag} !== {1'b1, 4'h5, 8'h10, 8'h02}) begin
               errors++; $display("FAIL add_const got=%h exp=%h", {cdbvalid, cdbtag, cdbval, cdbflag}, {1'b1, 4'h5, 8'h10, 8'h02});
            end
            checks++;
         end
      end
      if (obs[36:0] !== 37'd0) begin errors++; $display("FAIL add_idle got=%h exp=0", obs[36:0]); end
      checks++;
      cycle_in(1, 0, 8'd1, 8'h03, 8'h03, 8'h00, 8'h01, 8'd6);
      if (obs !== exp_out) begin errors++; $display("FAIL sub_vec got=%h exp=%h", obs, exp_out); end
      checks++;
      cycle_in(1, 0, 8'd5, 8'h81, 8'h09, 8'h00, 8'h02, 8'd7);
      if (obs !== exp_out) begin errors++; $display("FAIL shl_vec got=%h exp=%h", obs, exp_out); end
      checks++;
      cycle_in(1, 0, 8'h40, 8'h5A, 8'hA5, 8'h01, 8'h03, 8'd8);
      if (obs !== exp_out) begin errors++; $display("FAIL badop_vec got=%h exp=%h", obs, exp_out); end
      checks++;
      for (int k = 0; k < 60; k++) begin
         if (k < 50) rand_cycle(($urandom % 10 < 7) && !m_busy_prev, ($urandom % 10 < 3));
         else        rand_cycle(0, 0);
         if (obs !== exp_out) begin errors++; $display("FAIL rand_ops k=%0d got=%h exp=%h", k, obs, exp_out); end
         checks++;
      end
   endtask

   task automatic test_backpressure();
      int  issued = 0;
      bit  stop   = fubusyout;
      for (int k = 0; k < 8; k++) begin
         cycle_in(!stop, 1, 8'd0, 8'($urandom), 8'($urandom), 8'h00, 8'(k), 8'(16 + k));
         if (!stop) issued++;
         if (obs !== exp_out) begin errors++; $display("FAIL bp_fill k=%0d got=%h exp=%h", k, obs, exp_out); end
         checks++;
         if (fubusyout) stop = 1;
      end
      if (issued !== DEPTH) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", issued, DEPTH); end
      checks++;
      if (fubusyout !== 1'b1) begin errors++; $display("FAIL bp_held got=%b exp=1", fubusyout); end
      checks++;
      for (int k = 0; k < 6; k++) begin
         cycle_in(0, 0, 0, 0, 0, 0, 0, 0);
         if (obs !== exp_out) begin errors++; $display("FAIL bp_drain k=%0d got=%h exp=%h", k, obs, exp_out); end
         checks++;
         if (k < DEPTH && cdbvalid !== 1'b1) begin errors++; $display("FAIL bp_consec k=%0d got=%b exp=1", k, cdbvalid); end
         if (k < DEPTH) checks++;
      end
   endtask

   task automatic test_chain();
      for (int k = 0; k < 4; k++) begin
         rand_cycle(k < 2, 1);
         if (obs !== exp_out) begin errors++; $display("FAIL chain_fill k=%0d got=%h exp=%h", k, obs, exp_out); end
         checks++;
      end
      for (int k = 0; k < 6; k++) begin
         cycle_in(0, (k % 2) == 0, 0, 0, 0, 0, 0, 0);
         if (obs !== exp_out) begin errors++; $display("FAIL chain_toggle k=%0d got=%h exp=%h", k, obs, exp_out); end
         checks++;
         if (k < 4 && cdbclaimedout !== 1'b1) begin errors++; $display("FAIL chain_claim k=%0d got=%b exp=1", k, cdbclaimedout); end
         if (k < 4) checks++;
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 24; k++) begin
         rand_cycle(k < 20, 0);
         if (obs !== exp_out) begin errors++; $display("FAIL b2b k=%0d got=%h exp=%h", k, obs, exp_out); end
         checks++;
         if (fubusyout !== 1'b0) begin errors++; $display("FAIL b2b_busy k=%0d got=%b exp=0", k, fubusyout); end
         checks++;
      end
   endtask

   task automatic test_reset_mid();
      rand_cycle(1, 1);
      rand_cycle(1, 1);
      rand_cycle(0, 1);
      rand_cycle(1, 1);
      rand_cycle(1, 0);
      if (obs !== exp_out) begin errors++; $display("FAIL mid_pre got=%h exp=%h", obs, exp_out); end
      checks++;
      #1 rst = 1'b1;
      #1;
      if (obs !== 39'd0) begin errors++; $display("FAIL mid_reset got=%h exp=%h", obs, 39'd0); end
      checks++;
      model_reset();
      futransmit = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k == 6) rand_cycle(1, 0);
         else        cycle_in(0, 0, 0, 0, 0, 0, 0, 0);
         if (obs !== exp_out) begin errors++; $display("FAIL mid_after k=%0d got=%h exp=%h", k, obs, exp_out); end
         checks++;
         if (k < 8 && cdbvalid !== 1'b0) begin errors++; $display("FAIL mid_quiet k=%0d got=%b exp=0", k, cdbvalid); end
         if (k < 8) checks++;
      end
   endtask

   initial begin
      rst = 1'b1; futransmit = 1'b0; cdbclaimedin = 1'b0; operandin = '0;
      wbsin = '0; flagin = '0; robidin = '0; depvalsin = '0;
      cyc = 0;
      model_reset();
      test_reset();
      test_ops();
      test_backpressure();
      test_chain();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
